// File: rtl/hazard_info_pipe.sv
// Hazard-interface producer: decodes T_use/source needs for the D-stage instruction
// and carries destination register plus remaining T_new down the E/M/W pipeline.
module hazard_info_pipe #(
  parameter logic [4:0] TUSE_NONE = 5'd3,
  parameter logic [4:0] LINK_REG  = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_D,
  input  logic        flush_E,
  output logic [4:0]  T_use_rs,
  output logic [4:0]  T_use_rt,
  output logic [4:0]  rs_need_D,
  output logic [4:0]  rt_need_D,
  output logic [4:0]  rs_need_E,
  output logic [4:0]  rt_need_E,
  output logic [4:0]  T_new_E,
  output logic [4:0]  T_new_M,
  output logic [4:0]  T_new_W,
  output logic [4:0]  WriteReg_need_E,
  output logic [4:0]  WriteReg_need_M,
  output logic [4:0]  WriteReg_need_W,
  output logic [31:0] Instr_E,
  output logic [31:0] Instr_M,
  output logic [31:0] Instr_W
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_LINK    = 6'b011000;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rsField;
  logic [4:0] rtField;
  logic [4:0] rdField;

  assign opcode  = Instr_D[31:26];
  assign rsField = Instr_D[25:21];
  assign rtField = Instr_D[20:16];
  assign rdField = Instr_D[15:11];
  assign funct   = Instr_D[5:0];

  logic [4:0] destRaw;
  logic [4:0] tnewRaw;
  logic [4:0] destDec;
  logic [4:0] tnewDec;

  always_comb begin
    T_use_rs  = TUSE_NONE;
    T_use_rt  = TUSE_NONE;
    rs_need_D = 5'd0;
    rt_need_D = 5'd0;
    destRaw   = 5'd0;
    tnewRaw   = 5'd0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU, FN_SUBU: begin
            T_use_rs  = 5'd1;
            T_use_rt  = 5'd1;
            rs_need_D = rsField;
            rt_need_D = rtField;
            destRaw   = rdField;
            tnewRaw   = 5'd1;
          end
          FN_JR: begin
            T_use_rs  = 5'd0;
            rs_need_D = rsField;
          end
          default: begin
          end
        endcase
      end
      OP_ORI, OP_ADDIU: begin
        T_use_rs  = 5'd1;
        rs_need_D = rsField;
        destRaw   = rtField;
        tnewRaw   = 5'd1;
      end
      OP_LUI: begin
        destRaw = rtField;
        tnewRaw = 5'd1;
      end
      OP_LW: begin
        T_use_rs  = 5'd1;
        rs_need_D = rsField;
        destRaw   = rtField;
        tnewRaw   = 5'd2;
      end
      OP_SW: begin
        T_use_rs  = 5'd1;
        T_use_rt  = 5'd2;
        rs_need_D = rsField;
        rt_need_D = rtField;
      end
      OP_BEQ: begin
        T_use_rs  = 5'd0;
        T_use_rt  = 5'd0;
        rs_need_D = rsField;
        rt_need_D = rtField;
      end
      OP_JAL, OP_LINK: begin
        destRaw = LINK_REG;
        tnewRaw = 5'd0;
      end
      default: begin
      end
    endcase
  end

  // A write to $0 is no write at all, so it must never look like a pending producer.
  assign destDec = destRaw;
  assign tnewDec = (destRaw == 5'd0) ? 5'd0 : tnewRaw;

  logic [31:0] instrEQ, instrED;
  logic [4:0]  rsEQ, rsED;
  logic [4:0]  rtEQ, rtED;
  logic [4:0]  destEQ, destED;
  logic [4:0]  tnewEQ, tnewED;

  always_comb begin
    instrED = Instr_D;
    rsED    = rs_need_D;
    rtED    = rt_need_D;
    destED  = destDec;
    tnewED  = tnewDec;
    if (flush_E) begin
      instrED = 32'd0;
      rsED    = 5'd0;
      rtED    = 5'd0;
      destED  = 5'd0;
      tnewED  = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instrEQ <= 32'd0;
      rsEQ    <= 5'd0;
      rtEQ    <= 5'd0;
      destEQ  <= 5'd0;
      tnewEQ  <= 5'd0;
    end else begin
      instrEQ <= instrED;
      rsEQ    <= rsED;
      rtEQ    <= rtED;
      destEQ  <= destED;
      tnewEQ  <= tnewED;
    end
  end

  logic [31:0] instrMQ, instrMD;
  logic [4:0]  destMQ, destMD;
  logic [4:0]  tnewMQ, tnewMD;

  always_comb begin
    instrMD = instrEQ;
    destMD  = destEQ;
    tnewMD  = (tnewEQ == 5'd0) ? 5'd0 : tnewEQ - 5'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instrMQ <= 32'd0;
      destMQ  <= 5'd0;
      tnewMQ  <= 5'd0;
    end else begin
      instrMQ <= instrMD;
      destMQ  <= destMD;
      tnewMQ  <= tnewMD;
    end
  end

  logic [31:0] instrWQ, instrWD;
  logic [4:0]  destWQ, destWD;
  logic [4:0]  tnewWQ, tnewWD;

  always_comb begin
    instrWD = instrMQ;
    destWD  = destMQ;
    tnewWD  = (tnewMQ == 5'd0) ? 5'd0 : tnewMQ - 5'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instrWQ <= 32'd0;
      destWQ  <= 5'd0;
      tnewWQ  <= 5'd0;
    end else begin
      instrWQ <= instrWD;
      destWQ  <= destWD;
      tnewWQ  <= tnewWD;
    end
  end

  assign Instr_E         = instrEQ;
  assign rs_need_E       = rsEQ;
  assign rt_need_E       = rtEQ;
  assign WriteReg_need_E = destEQ;
  assign T_new_E         = tnewEQ;
  assign Instr_M         = instrMQ;
  assign WriteReg_need_M = destMQ;
  assign T_new_M         = tnewMQ;
  assign Instr_W         = instrWQ;
  assign WriteReg_need_W = destWQ;
  assign T_new_W         = tnewWQ;

endmodule

// File: tb/tb_hazard_info_pipe.sv
// Directed bench for hazard_info_pipe: decode vector table with a small E/M/W
// shadow model, plus hand-written reset, load-drain, flush and link sequences.
module tb_hazard_info_pipe;

  logic        clk;
  logic        reset;
  logic [31:0] Instr_D;
  logic        flush_E;
  logic [4:0]  T_use_rs, T_use_rt, rs_need_D, rt_need_D, rs_need_E, rt_need_E;
  logic [4:0]  T_new_E, T_new_M, T_new_W;
  logic [4:0]  WriteReg_need_E, WriteReg_need_M, WriteReg_need_W;
  logic [31:0] Instr_E, Instr_M, Instr_W;

  int checks = 0;
  int errors = 0;

  hazard_info_pipe dut (
    .clk(clk), .reset(reset), .Instr_D(Instr_D), .flush_E(flush_E),
    .T_use_rs(T_use_rs), .T_use_rt(T_use_rt),
    .rs_need_D(rs_need_D), .rt_need_D(rt_need_D),
    .rs_need_E(rs_need_E), .rt_need_E(rt_need_E),
    .T_new_E(T_new_E), .T_new_M(T_new_M), .T_new_W(T_new_W),
    .WriteReg_need_E(WriteReg_need_E), .WriteReg_need_M(WriteReg_need_M),
    .WriteReg_need_W(WriteReg_need_W),
    .Instr_E(Instr_E), .Instr_M(Instr_M), .Instr_W(Instr_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  tuseRs;
    logic [4:0]  tuseRt;
    logic [4:0]  rsNeed;
    logic [4:0]  rtNeed;
    logic [4:0]  destE;
    logic [4:0]  tnewE;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [4:0] satDec(input logic [4:0] v);
    return (v == 5'd0) ? 5'd0 : v - 5'd1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic flush);
    Instr_D = instr;
    flush_E = flush;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] mInstrE, mInstrM, mInstrW;
  logic [4:0]  mDestE, mDestM, mDestW, mTnewE, mTnewM, mTnewW;
  logic [31:0] lwI, adduI, jalI;

  initial begin
    vecs[0]  = '{rType(5'd1, 5'd2, 5'd3, 6'h21),        5'd1, 5'd1, 5'd1,  5'd2, 5'd3,  5'd1};
    vecs[1]  = '{rType(5'd5, 5'd6, 5'd4, 6'h23),        5'd1, 5'd1, 5'd5,  5'd6, 5'd4,  5'd1};
    vecs[2]  = '{rType(5'd31, 5'd0, 5'd0, 6'h08),       5'd0, 5'd3, 5'd31, 5'd0, 5'd0,  5'd0};
    vecs[3]  = '{iType(6'h0d, 5'd8, 5'd7, 16'h00ff),    5'd1, 5'd3, 5'd8,  5'd0, 5'd7,  5'd1};
    vecs[4]  = '{iType(6'h09, 5'd10, 5'd9, 16'hfffc),   5'd1, 5'd3, 5'd10, 5'd0, 5'd9,  5'd1};
    vecs[5]  = '{iType(6'h0f, 5'd5, 5'd3, 16'h1234),    5'd3, 5'd3, 5'd0,  5'd0, 5'd3,  5'd1};
    vecs[6]  = '{iType(6'h23, 5'd4, 5'd5, 16'h0000),    5'd1, 5'd3, 5'd4,  5'd0, 5'd5,  5'd2};
    vecs[7]  = '{iType(6'h2b, 5'd9, 5'd8, 16'h0004),    5'd1, 5'd2, 5'd9,  5'd8, 5'd0,  5'd0};
    vecs[8]  = '{iType(6'h04, 5'd1, 5'd2, 16'h0010),    5'd0, 5'd0, 5'd1,  5'd2, 5'd0,  5'd0};
    vecs[9]  = '{{6'h03, 26'h0000100},                  5'd3, 5'd3, 5'd0,  5'd0, 5'd31, 5'd0};
    vecs[10] = '{{6'h18, 26'h3ffffff},                  5'd3, 5'd3, 5'd0,  5'd0, 5'd31, 5'd0};
    vecs[11] = '{rType(5'd1, 5'd2, 5'd0, 6'h21),        5'd1, 5'd1, 5'd1,  5'd2, 5'd0,  5'd0};
    vecs[12] = '{{6'h3f, 26'h1234567},                  5'd3, 5'd3, 5'd0,  5'd0, 5'd0,  5'd0};
    vecs[13] = '{32'h0,                                 5'd3, 5'd3, 5'd0,  5'd0, 5'd0,  5'd0};
    vecs[14] = '{rType(5'd1, 5'd2, 5'd3, 6'h20),        5'd3, 5'd3, 5'd0,  5'd0, 5'd0,  5'd0};

    lwI   = iType(6'h23, 5'd4, 5'd5, 16'h0000);
    adduI = rType(5'd1, 5'd2, 5'd3, 6'h21);
    jalI  = {6'h03, 26'h0000040};

    reset = 1'b0;
    applyStimulus(32'h0, 1'b0);
    #3;
    checkOutput("resetInstrE", Instr_E, 32'd0);
    checkOutput("resetTnewE", {27'd0, T_new_E}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Decode table, with a shadow model of how each entry drains through M and W.
    mInstrE = 0; mInstrM = 0; mInstrW = 0;
    mDestE = 0; mDestM = 0; mDestW = 0; mTnewE = 0; mTnewM = 0; mTnewW = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].instr, 1'b0);
      checkOutput($sformatf("v%0d T_use_rs", i), {27'd0, T_use_rs}, {27'd0, vecs[i].tuseRs});
      checkOutput($sformatf("v%0d T_use_rt", i), {27'd0, T_use_rt}, {27'd0, vecs[i].tuseRt});
      checkOutput($sformatf("v%0d rs_need_D", i), {27'd0, rs_need_D}, {27'd0, vecs[i].rsNeed});
      checkOutput($sformatf("v%0d rt_need_D", i), {27'd0, rt_need_D}, {27'd0, vecs[i].rtNeed});
      tick();
      mInstrW = mInstrM; mDestW = mDestM; mTnewW = satDec(mTnewM);
      mInstrM = mInstrE; mDestM = mDestE; mTnewM = satDec(mTnewE);
      mInstrE = vecs[i].instr; mDestE = vecs[i].destE; mTnewE = vecs[i].tnewE;
      checkOutput($sformatf("v%0d Instr_E", i), Instr_E, mInstrE);
      checkOutput($sformatf("v%0d rs_need_E", i), {27'd0, rs_need_E}, {27'd0, vecs[i].rsNeed});
      checkOutput($sformatf("v%0d rt_need_E", i), {27'd0, rt_need_E}, {27'd0, vecs[i].rtNeed});
      checkOutput($sformatf("v%0d WriteReg_need_E", i), {27'd0, WriteReg_need_E}, {27'd0, mDestE});
      checkOutput($sformatf("v%0d T_new_E", i), {27'd0, T_new_E}, {27'd0, mTnewE});
      checkOutput($sformatf("v%0d Instr_M", i), Instr_M, mInstrM);
      checkOutput($sformatf("v%0d WriteReg_need_M", i), {27'd0, WriteReg_need_M}, {27'd0, mDestM});
      checkOutput($sformatf("v%0d T_new_M", i), {27'd0, T_new_M}, {27'd0, mTnewM});
      checkOutput($sformatf("v%0d Instr_W", i), Instr_W, mInstrW);
      checkOutput($sformatf("v%0d WriteReg_need_W", i), {27'd0, WriteReg_need_W}, {27'd0, mDestW});
      checkOutput($sformatf("v%0d T_new_W", i), {27'd0, T_new_W}, {27'd0, mTnewW});
    end

    // Load drain: lw $5 then three nops; counter must stop at zero.
    applyStimulus(lwI, 1'b0);
    tick();
    checkOutput("load E tnew", {27'd0, T_new_E}, 32'd2);
    checkOutput("load E dest", {27'd0, WriteReg_need_E}, 32'd5);
    applyStimulus(32'h0, 1'b0);
    tick();
    checkOutput("load M tnew", {27'd0, T_new_M}, 32'd1);
    checkOutput("load M dest", {27'd0, WriteReg_need_M}, 32'd5);
    checkOutput("load M instr", Instr_M, lwI);
    tick();
    checkOutput("load W tnew", {27'd0, T_new_W}, 32'd0);
    checkOutput("load W dest", {27'd0, WriteReg_need_W}, 32'd5);
    checkOutput("load W instr", Instr_W, lwI);
    tick();
    checkOutput("load drained W dest", {27'd0, WriteReg_need_W}, 32'd0);

    // Flush: lw in E, addu $6,$5,$7 stalled in D for one cycle.
    applyStimulus(lwI, 1'b0);
    tick();
    applyStimulus(rType(5'd5, 5'd7, 5'd6, 6'h21), 1'b1);
    tick();
    checkOutput("flush E instr", Instr_E, 32'd0);
    checkOutput("flush E rs", {27'd0, rs_need_E}, 32'd0);
    checkOutput("flush E rt", {27'd0, rt_need_E}, 32'd0);
    checkOutput("flush E dest", {27'd0, WriteReg_need_E}, 32'd0);
    checkOutput("flush E tnew", {27'd0, T_new_E}, 32'd0);
    checkOutput("flush M tnew", {27'd0, T_new_M}, 32'd1);
    checkOutput("flush M dest", {27'd0, WriteReg_need_M}, 32'd5);
    applyStimulus(rType(5'd5, 5'd7, 5'd6, 6'h21), 1'b0);
    tick();
    checkOutput("post-flush E rs", {27'd0, rs_need_E}, 32'd5);
    checkOutput("post-flush E rt", {27'd0, rt_need_E}, 32'd7);
    checkOutput("post-flush E dest", {27'd0, WriteReg_need_E}, 32'd6);
    checkOutput("post-flush M bubble", Instr_M, 32'd0);
    checkOutput("post-flush W dest", {27'd0, WriteReg_need_W}, 32'd5);

    // Link: jal keeps dest 31 and T_new 0 through every stage.
    applyStimulus(jalI, 1'b0);
    tick();
    checkOutput("link E dest", {27'd0, WriteReg_need_E}, 32'd31);
    checkOutput("link E tnew", {27'd0, T_new_E}, 32'd0);
    applyStimulus(32'h0, 1'b0);
    tick();
    checkOutput("link M dest", {27'd0, WriteReg_need_M}, 32'd31);
    checkOutput("link M tnew", {27'd0, T_new_M}, 32'd0);
    tick();
    checkOutput("link W dest", {27'd0, WriteReg_need_W}, 32'd31);
    checkOutput("link W tnew", {27'd0, T_new_W}, 32'd0);

    // Asynchronous reset mid-stream with lw sitting in M.
    applyStimulus(lwI, 1'b0);
    tick();
    applyStimulus(adduI, 1'b0);
    tick();
    checkOutput("pre-reset M dest", {27'd0, WriteReg_need_M}, 32'd5);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("areset Instr_E", Instr_E, 32'd0);
    checkOutput("areset Instr_M", Instr_M, 32'd0);
    checkOutput("areset Instr_W", Instr_W, 32'd0);
    checkOutput("areset T_new_M", {27'd0, T_new_M}, 32'd0);
    checkOutput("areset dest M", {27'd0, WriteReg_need_M}, 32'd0);
    checkOutput("areset dest E", {27'd0, WriteReg_need_E}, 32'd0);
    checkOutput("areset rs_need_E", {27'd0, rs_need_E}, 32'd0);
    checkOutput("areset D decode", {27'd0, T_use_rs}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    checkOutput("release Instr_E", Instr_E, adduI);
    checkOutput("release T_new_E", {27'd0, T_new_E}, 32'd1);
    checkOutput("release dest E", {27'd0, WriteReg_need_E}, 32'd3);
    checkOutput("release Instr_M", Instr_M, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_info_pipe.md
Name: hazard_info_pipe

Overview:
- Producer side of the hazard interface. Decodes the D-stage instruction into T_use and source-register fields.
- Carries each instruction's destination register and remaining T_new down the E/M/W pipeline registers, decrementing T_new once per stage.
- Feeds the stall/forward unit and consumes that unit's D-to-E flush (bubble) request.
- Sits beside the datapath pipeline registers and advances in lockstep with them.

Parameters:
- TUSE_NONE, 3, T_use value for an unused source operand; never triggers a stall.
- LINK_REG, 31, destination register for link-writing instructions.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Instr_D  in  32  instruction currently in D.
- flush_E  in  1  1 = load a bubble into E this edge (stall/flush from hazard unit).
- T_use_rs  out  5  combinational from Instr_D.
- T_use_rt  out  5  combinational from Instr_D.
- rs_need_D  out  5  combinational from Instr_D.
- rt_need_D  out  5  combinational from Instr_D.
- rs_need_E  out  5  registered, from the E register.
- rt_need_E  out  5  registered, from the E register.
- T_new_E  out  5  registered.
- T_new_M  out  5  registered.
- T_new_W  out  5  registered.
- WriteReg_need_E  out  5  registered.
- WriteReg_need_M  out  5  registered.
- WriteReg_need_W  out  5  registered.
- Instr_E  out  32  registered.
- Instr_M  out  32  registered.
- Instr_W  out  32  registered.

Behaviour:
- Decode table: (T_use_rs, T_use_rt, dest, T_new at E). Unused source: need field = 0, T_use = TUSE_NONE.
  - addu/subu (op 0, funct 100001/100011): 1, 1, rd, 1.
  - jr (op 0, funct 001000): 0, none, no write.
  - ori 001101 and addiu 001001: 1, none, rt, 1.
  - lui 001111: none, none, rt, 1.
  - lw 100011: 1, none, rt, 2.
  - sw 101011: 1, 2, no write.
  - beq 000100: 0, 0, no write.
  - jal 000011 and link op 011000: none, none, LINK_REG, 0.
  - All other encodings, including 32'h0: nop; all uses none, no write.
- "No write" means dest = 0 and T_new = 0. A decoded dest of 0 (e.g. addu $0,...) is likewise normalised to dest = 0, T_new = 0.
- E register update each edge:
  - flush_E = 1: bubble (Instr 0, rs/rt 0, dest 0, T_new 0).
  - otherwise: load decoded D fields.
- M register: always loads from E. T_new_M = T_new_E - 1, saturating at 0.
- W register: always loads from M. T_new_W = T_new_M - 1, saturating at 0.
- Latency:
  - D outputs: 0 cycles.
  - E fields: 1 edge after the instruction is in D.
  - M fields: 2 edges.
  - W fields: 3 edges.
- Reset (reset = 0, asynchronous, any time): all registered outputs go to 0 immediately, i.e. the whole pipe holds bubbles. D outputs still follow Instr_D. First edge after release behaves normally.
- flush_E held for N cycles: N consecutive bubbles enter E. M/W keep draining.
- Instr_D is not latched here; the external F/D register holds it during a stall.
- All registered fields of one instruction move together; no field may lag its Instr_x.

Test Plan:
- Reset: reset = 0 mid-stream with lw in M -> all E/M/W outputs read 0 before the next edge; release, feed addu $3,$1,$2 -> one edge later Instr_E matches, T_new_E = 1, WriteReg_need_E = 3.
- Load pipe: lw $5,0($4) then 3 nops -> E: T_new 2 / dest 5; M: T_new 1 / dest 5; W: T_new 0 / dest 5. The counter never underflows.
- Flush: lw $5 in E, D = addu $6,$5,$7 with flush_E = 1 for 1 cycle -> E becomes bubble (all 0), M gets lw with T_new_M = 1; next edge addu enters E with rs_need_E = 5.
- Decode uses: beq $1,$2 -> T_use_rs = 0, T_use_rt = 0. sw $8,4($9) -> T_use_rs = 1, T_use_rt = 2, rt_need_D = 8. lui $3 -> both T_use = 3, need fields 0.
- Link: jal and opcode 011000 -> WriteReg_need_E = 31, T_new_E = 0, then T_new_M = 0, T_new_W = 0.
- Zero dest / unknown: addu $0,$1,$2 and opcode 111111 -> WriteReg_need_E = 0, T_new_E = 0.
